// File: rtl/cordic_phase_pkg.sv
// Shared constants for the CORDIC phase source: accumulator modulus,
// quadrant codes, quadrant boundaries, FSM states and a degree wrap helper.
// Optional feature macro used by this slice: PHASE_OFFSET_EN.
package cordic_phase_pkg;

    localparam int unsigned FRAC_W_DEF = 8;
    localparam int unsigned DEG_FULL   = 360;
    localparam int unsigned MOD_DEF    = DEG_FULL << FRAC_W_DEF;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [8:0] B90  = 9'd90;
    localparam logic [8:0] B180 = 9'd180;
    localparam logic [8:0] B270 = 9'd270;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Fold a degree value below 720 back into 0..359 with one subtraction.
    function automatic logic [8:0] wrap360(input logic [9:0] d);
        if (d >= 10'd360) begin
            return 9'(d - 10'd360);
        end
        return d[8:0];
    endfunction

endpackage

// File: rtl/cordic_phase_map.sv
// Combinational degree -> {quadrant, in-quadrant angle} mapper.
// Upper quadrant bounds are inclusive (90 -> {Q0,90}).
// With PHASE_OFFSET_EN defined, a 0..359 offset is added modulo 360 first.
module cordic_phase_map
    import cordic_phase_pkg::*;
(
    input  logic [8:0]  deg,
`ifdef PHASE_OFFSET_EN
    input  logic [8:0]  offset,
`endif
    output logic [1:0]  quad,
    output logic [15:0] angle
);

    logic [8:0] deg_eff;
    logic [8:0] rel;

    // Apply optional offset, then classify into a quadrant and relative angle.
    always_comb begin
`ifdef PHASE_OFFSET_EN
        deg_eff = wrap360({1'b0, deg} + {1'b0, offset});
`else
        deg_eff = deg;
`endif
        quad = Q0;
        rel  = deg_eff;
        if (deg_eff <= B90) begin
            quad = Q0;
            rel  = deg_eff;
        end else if (deg_eff <= B180) begin
            quad = Q1;
            rel  = deg_eff - B90;
        end else if (deg_eff <= B270) begin
            quad = Q2;
            rel  = deg_eff - B180;
        end else begin
            quad = Q3;
            rel  = deg_eff - B270;
        end
        angle = {7'd0, rel};
    end

endmodule

// File: rtl/cordic_phase_gen.sv
// Start/stop, sample-counted, valid/ready phase source for the CORDIC core.
// A fractional-degree accumulator is advanced on every handshake and its
// integer part is emitted quadrant-encoded on Phase[17:0].
// Optional feature macro: PHASE_OFFSET_EN (adds the Offset input).
module cordic_phase_gen
    import cordic_phase_pkg::*;
#(
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned ACC_W  = 9 + FRAC_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             CLK_50M,
    input  logic             RST_N,
    input  logic             Start,
    input  logic             Stop,
    input  logic [ACC_W-1:0] Step,
    input  logic [CNT_W-1:0] Num_Samples,
`ifdef PHASE_OFFSET_EN
    input  logic [8:0]       Offset,
`endif
    output logic [31:0]      Phase,
    output logic             Phase_Valid,
    input  logic             Phase_Ready,
    output logic             Busy,
    output logic             Done,
    output logic             Step_Err
);

    localparam int unsigned MOD   = DEG_FULL << FRAC_W;
    localparam logic [ACC_W:0] MOD_X = MOD[ACC_W:0];

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [17:0]      phase_q, phase_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
`ifdef PHASE_OFFSET_EN
    logic [8:0]       offset_q, offset_d;
    logic [8:0]       offset_in;
    logic [8:0]       map_off;
`endif

    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_next;
    logic             step_bad;
    logic             hs;
    logic             last;
    logic [8:0]       map_deg;
    logic [1:0]       map_quad;
    logic [15:0]      map_angle;

    // Accumulator wrap, start validation and handshake/termination decode.
    always_comb begin
        acc_sum = {1'b0, acc_q} + {1'b0, step_q};
        if (acc_sum >= MOD_X) begin
            acc_next = ACC_W'(acc_sum - MOD_X);
        end else begin
            acc_next = ACC_W'(acc_sum);
        end
        step_bad = (Step == '0) || ({1'b0, Step} >= MOD_X);
        hs       = valid_q & Phase_Ready;
        last     = (num_q != '0) && (cnt_q == num_q - CNT_W'(1));
    end

    // In IDLE the mapper produces the first sample (deg 0) so that it can be
    // registered on the accepting edge; in RUN it maps the next accumulator.
    always_comb begin
        map_deg = (state_q == IDLE) ? '0 : acc_next[ACC_W-1:FRAC_W];
`ifdef PHASE_OFFSET_EN
        offset_in = wrap360({1'b0, Offset});
        map_off   = (state_q == IDLE) ? offset_in : offset_q;
`endif
    end

    cordic_phase_map u_map (
        .deg    (map_deg),
`ifdef PHASE_OFFSET_EN
        .offset (map_off),
`endif
        .quad   (map_quad),
        .angle  (map_angle)
    );

    // Next-state logic for the IDLE/RUN sequencer and its registered outputs.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        phase_d = phase_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef PHASE_OFFSET_EN
        offset_d = offset_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (Start && !Stop) begin
                    if (step_bad) begin
                        err_d = 1'b1;
                    end else begin
                        step_d  = Step;
                        num_d   = Num_Samples;
                        acc_d   = '0;
                        cnt_d   = '0;
                        phase_d = {map_quad, map_angle};
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = RUN;
`ifdef PHASE_OFFSET_EN
                        offset_d = offset_in;
`endif
                    end
                end
            end
            RUN: begin
                if (hs) begin
                    acc_d   = acc_next;
                    cnt_d   = cnt_q + CNT_W'(1);
                    phase_d = {map_quad, map_angle};
                end
                // A final counted handshake takes priority over Stop so the
                // sweep still reports completion.
                if (hs && last) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (Stop) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            phase_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef PHASE_OFFSET_EN
            offset_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef PHASE_OFFSET_EN
            offset_q <= offset_d;
`endif
        end
    end

    assign Phase       = {14'd0, phase_q};
    assign Phase_Valid = valid_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Step_Err    = err_q;

endmodule
